// File: rtl/mvm_ctrl.sv
// Command sequencer for the mvm crossbar unit: turns LOAD_WT / RUN_MVM / LOAD_RUN
// commands into registered mvm strobes, counts passes, times out mvm_done, returns a tagged response.
module mvm_ctrl #(
   parameter int PROG_CYCLES = 2,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_W       = 11,
   parameter int ITER_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ITER_W-1:0] cmd_iter,
   input  logic [3:0]        cmd_tag,
   output logic              mvm_reset,
   output logic              reset_wt,
   output logic              prog_wt,
   output logic              mvm_start,
   input  logic              mvm_done,
   output logic [ITER_W-1:0] in_sel,
   output logic              busy,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [3:0]        rsp_tag,
   output logic              rsp_err
);

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_LOAD_WT  = 2'b01;
   localparam logic [1:0] OP_RUN_MVM  = 2'b10;
   localparam logic [1:0] OP_LOAD_RUN = 2'b11;

   localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WT_CLR,
      WT_PROG,
      MVM_RST,
      MVM_RUN,
      MVM_WAIT,
      RESP
   } state_t;

   state_t              state_reg, state_next;
   logic [1:0]          op_reg, op_next;
   logic [ITER_W-1:0]   iter_reg, iter_next;
   logic [3:0]          tag_reg, tag_next;
   logic [ITER_W-1:0]   in_sel_reg, in_sel_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                err_reg, err_next;
   logic                abort;

   logic                mvm_reset_reg, reset_wt_reg, prog_wt_reg, mvm_start_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         op_reg        <= OP_NOP;
         iter_reg      <= '0;
         tag_reg       <= '0;
         in_sel_reg    <= '0;
         cnt_reg       <= '0;
         err_reg       <= 1'b0;
         mvm_reset_reg <= 1'b0;
         reset_wt_reg  <= 1'b0;
         prog_wt_reg   <= 1'b0;
         mvm_start_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         op_reg        <= op_next;
         iter_reg      <= iter_next;
         tag_reg       <= tag_next;
         in_sel_reg    <= in_sel_next;
         cnt_reg       <= cnt_next;
         err_reg       <= err_next;
         // Strobes are flops decoded from the next state, so mvm sees no combinational input path.
         mvm_reset_reg <= (state_next == WT_CLR) || (state_next == MVM_RST) || abort;
         reset_wt_reg  <= (state_next == WT_CLR);
         prog_wt_reg   <= (state_next == WT_PROG);
         mvm_start_reg <= (state_next == MVM_RUN);
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      iter_next   = iter_reg;
      tag_next    = tag_reg;
      in_sel_next = in_sel_reg;
      cnt_next    = cnt_reg;
      err_next    = err_reg;
      abort       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               op_next     = cmd_op;
               iter_next   = cmd_iter;
               tag_next    = cmd_tag;
               in_sel_next = '0;
               cnt_next    = '0;
               err_next    = 1'b0;
               case (cmd_op)
                  OP_LOAD_WT, OP_LOAD_RUN: state_next = WT_CLR;
                  OP_RUN_MVM:              state_next = MVM_RST;
                  default:                 state_next = RESP;
               endcase
            end
         end
         WT_CLR: begin
            cnt_next   = '0;
            state_next = WT_PROG;
         end
         WT_PROG: begin
            if (cnt_reg == PROG_LAST) begin
               cnt_next   = '0;
               state_next = (op_reg == OP_LOAD_RUN) ? MVM_RST : RESP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         MVM_RST: state_next = MVM_RUN;
         MVM_RUN: begin
            cnt_next   = '0;
            state_next = MVM_WAIT;
         end
         MVM_WAIT: begin
            // done is checked before the timeout so a done on the last wait cycle still succeeds
            if (mvm_done) begin
               if (in_sel_reg == iter_reg) begin
                  err_next   = 1'b0;
                  state_next = RESP;
               end else begin
                  in_sel_next = in_sel_reg + 1'b1;
                  state_next  = MVM_RST;
               end
            end else if (cnt_reg == TO_LAST) begin
               err_next   = 1'b1;
               abort      = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign rsp_tag   = tag_reg;
   assign rsp_err   = err_reg;
   assign in_sel    = in_sel_reg;
   assign mvm_reset = mvm_reset_reg;
   assign reset_wt  = reset_wt_reg;
   assign prog_wt   = prog_wt_reg;
   assign mvm_start = mvm_start_reg;

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl: responds to mvm_start like an mvm unit and checks
// strobe counts, pass indices, latencies and tagged responses against a response queue.
module tb_mvm_ctrl;

   localparam int PC = 2;
   localparam int TO = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [IW-1:0] cmd_iter = '0;
   logic [3:0]    cmd_tag = 4'h0;
   logic          mvm_reset, reset_wt, prog_wt, mvm_start;
   logic          mvm_done = 1'b0;
   logic [IW-1:0] in_sel;
   logic          busy, rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [3:0]    rsp_tag;
   logic          rsp_err;

   mvm_ctrl #(.PROG_CYCLES(PC), .TIMEOUT(TO), .CNT_W(11), .ITER_W(IW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_iter(cmd_iter), .cmd_tag(cmd_tag),
      .mvm_reset(mvm_reset), .reset_wt(reset_wt), .prog_wt(prog_wt),
      .mvm_start(mvm_start), .mvm_done(mvm_done), .in_sel(in_sel),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tag;
      logic       err;
   } rsp_t;
   rsp_t sb[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_rwt = 0, n_prog = 0, n_start = 0, n_mrst = 0;
   int b_rwt, b_prog, b_start, b_mrst;
   int a, s;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_wt)  n_rwt   <= n_rwt + 1;
      if (prog_wt)   n_prog  <= n_prog + 1;
      if (mvm_start) n_start <= n_start + 1;
      if (mvm_reset) n_mrst  <= n_mrst + 1;
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", name, obs, exp);
      end
   endtask

   task automatic snap();
      b_rwt = n_rwt; b_prog = n_prog; b_start = n_start; b_mrst = n_mrst;
   endtask

   task automatic deltas(input string name, input int rwt, input int prg, input int st, input int mr);
      chk({name, "_reset_wt_cycles"}, n_rwt - b_rwt, rwt);
      chk({name, "_prog_wt_cycles"}, n_prog - b_prog, prg);
      chk({name, "_start_pulses"}, n_start - b_start, st);
      chk({name, "_mvm_reset_cycles"}, n_mrst - b_mrst, mr);
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] iter, input logic [3:0] tag,
                       input logic err, output int acc);
      rsp_t e;
      for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_iter = iter; cmd_tag = tag;
      acc = cyc;
      e.tag = tag; e.err = err;
      sb.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Acts as the mvm unit: raises done d cycles after each start (d==0: never).
   task automatic serve(input int passes, input int d, output int st);
      st = 0;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < 200 && !mvm_start; i++) @(negedge clk);
         chk("start_seen", mvm_start, 1);
         chk("in_sel_pass", in_sel, p);
         chk("prog_off_in_mvm", prog_wt, 0);
         st = cyc;
         if (d > 0) begin
            repeat (d) @(negedge clk);
            mvm_done = 1'b1;
            @(negedge clk);
            mvm_done = 1'b0;
         end
      end
   endtask

   task automatic get_rsp(input int exp_cyc, input int hold);
      rsp_t e;
      e.tag = 4'h0; e.err = 1'b0;
      for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      if (exp_cyc >= 0) chk("rsp_latency", cyc, exp_cyc);
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      chk("rsp_tag", rsp_tag, e.tag);
      chk("rsp_err", rsp_err, e.err);
      for (int h = 0; h < hold; h++) begin
         if (h == 3) mvm_done = 1'b1;
         if (h == 4) mvm_done = 1'b0;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_tag", rsp_tag, e.tag);
         chk("hold_err", rsp_err, e.err);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      mvm_done  = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_strobes", {mvm_reset, reset_wt, prog_wt, mvm_start}, 0);
      chk("rst_in_sel", in_sel, 0);
      chk("rst_err_tag", {rsp_err, rsp_tag}, 0);
      reset = 1'b1;
      @(negedge clk);

      // LOAD_WT: clear 1 cycle, program PC cycles, respond
      snap();
      send(2'b01, 4'h0, 4'h3, 1'b0, a);
      get_rsp(a + 2 + PC, 0);
      deltas("load_wt", 1, PC, 0, 1);

      // RUN_MVM, three passes
      snap();
      send(2'b10, 4'h2, 4'h5, 1'b0, a);
      serve(3, 5, s);
      get_rsp(s + 6, 0);
      deltas("run3", 0, 0, 3, 3);

      // RUN_MVM single pass latency: accept -> rsp_valid = 3 + D
      send(2'b10, 4'h0, 4'h6, 1'b0, a);
      serve(1, 4, s);
      get_rsp(a + 3 + 4, 0);

      // LOAD_RUN
      snap();
      send(2'b11, 4'h0, 4'h9, 1'b0, a);
      serve(1, 3, s);
      chk("load_run_start_cycle", s, a + 3 + PC);
      get_rsp(s + 4, 0);
      deltas("load_run", 1, PC, 1, 2);

      // timeout: no done at all
      snap();
      send(2'b10, 4'h0, 4'hA, 1'b1, a);
      serve(1, 0, s);
      chk("to_start_cycle", s, a + 2);
      get_rsp(s + TO + 1, 0);
      deltas("timeout", 0, 0, 1, 2);

      // done on the last wait cycle beats the timeout
      snap();
      send(2'b10, 4'h0, 4'hB, 1'b0, a);
      serve(1, TO, s);
      get_rsp(s + TO + 1, 0);
      deltas("done_wins", 0, 0, 1, 1);

      // backpressure with a spurious done while in RESP
      snap();
      send(2'b10, 4'h1, 4'hC, 1'b0, a);
      serve(2, 2, s);
      get_rsp(-1, 10);
      deltas("backpressure", 0, 0, 2, 2);

      // all-ones iteration count: 16 passes, index must not wrap early
      snap();
      send(2'b10, 4'hF, 4'hD, 1'b0, a);
      serve(16, 1, s);
      get_rsp(s + 2, 0);
      deltas("iter_max", 0, 0, 16, 16);

      // NOP goes straight to the response
      send(2'b00, 4'h0, 4'hE, 1'b0, a);
      get_rsp(a + 1, 0);

      // reset in the middle of weight programming
      send(2'b01, 4'h0, 4'h7, 1'b0, a);
      @(negedge clk);
      chk("mid_prog_active", prog_wt, 1);
      reset = 1'b0;
      #1;
      chk("midrst_strobes", {mvm_reset, reset_wt, prog_wt, mvm_start}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_rsp_valid", rsp_valid, 0);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send(2'b00, 4'h0, 4'h1, 1'b0, a);
      get_rsp(a + 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
